// File: rtl/ws2812_string_driver_if.sv
// Purpose : pixel-word handshake into the WS2812 string driver.
// Latency : n/a (wires only); a word moves on an edge with valid and ready high.
// Backpr. : pix_ready_o low holds the producer; data must stay stable while valid.
// Ports   : pix_valid_i / pix_data_i driven by the producer (master),
//           pix_ready_o driven by the driver (slave).
interface ws2812_string_driver_if;
  logic        pix_valid_i;
  logic [23:0] pix_data_i;
  logic        pix_ready_o;

  modport master (output pix_valid_i, output pix_data_i, input pix_ready_o);
  modport slave  (input pix_valid_i, input pix_data_i, output pix_ready_o);
endinterface

// File: rtl/ws2812_string_driver.sv
// Purpose : serialise 24-bit GRB words onto the single-wire WS2812 LED line.
// Latency : push into an empty idle block -> first led_o rise two edges later.
// Backpr. : pix_ready_o drops while the pixel FIFO is full; pushes wait.
// Ports   : wb_clk_i/wb_rst_i clock and sync reset, pix (slave handshake),
//           led_o serial line, busy_o, fifo_level_o occupancy, done_o latch pulse.

// Purpose : small first-in first-out buffer with an occupancy count.
// Latency : pushed word is visible at the head one edge after the push.
// Backpr. : a push is refused while full, even on an edge that also pops.
module ws2812_fifo #(
  parameter int DW = 24,
  parameter int AW = 3
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          i_push_vld,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_dat,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_level == (AW+1)'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module ws2812_string_driver #(
  parameter int T0H_CYC  = 16,
  parameter int T1H_CYC  = 32,
  parameter int TBIT_CYC = 50,
  parameter int TRST_CYC = 2400,
  parameter int FIFO_AW  = 3
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  ws2812_string_driver_if.slave  pix,
  output logic                   led_o,
  output logic                   busy_o,
  output logic [FIFO_AW:0]       fifo_level_o,
  output logic                   done_o
);
  // One counter serves both the bit period and the latch period.
  localparam int CNT_MAX = (TBIT_CYC - 1 > TRST_CYC) ? TBIT_CYC - 1 : TRST_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_BIT_LAST   = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] C_LATCH_LAST = CW'(TRST_CYC);
  localparam logic [CW-1:0] C_T0H        = CW'(T0H_CYC);
  localparam logic [CW-1:0] C_T1H        = CW'(T1H_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_bit_idx, w_bit_idx_nxt;
  logic [23:0] r_shift, w_shift_nxt;
  logic        r_led, r_busy, r_done;
  logic        w_led_nxt, w_done_nxt, w_pop;
  logic [23:0] w_head_dat;
  logic        w_full, w_empty;

  ws2812_fifo #(.DW(24), .AW(FIFO_AW)) u_fifo (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .i_push_vld (pix.pix_valid_i),
    .i_push_dat (pix.pix_data_i),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_level    (fifo_level_o),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign pix.pix_ready_o = ~w_full;
  assign led_o  = r_led;
  assign busy_o = r_busy;
  assign done_o = r_done;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_done_nxt    = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head_dat;
          w_bit_idx_nxt = 5'd23;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == 5'd0) begin
            // Next word, if already queued, follows with no gap.
            if (!w_empty) begin
              w_pop         = 1'b1;
              w_shift_nxt   = w_head_dat;
              w_bit_idx_nxt = 5'd23;
            end else begin
              w_state_nxt = S_LATCH;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx - 1'b1;
            w_shift_nxt   = {r_shift[22:0], 1'b0};
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        // TRST_CYC full low cycles after the last bit, then a terminal
        // cycle hands back to IDLE; done_o marks the first IDLE cycle.
        if (r_cnt == C_LATCH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Line level is registered from the state the next cycle will be in;
    // the current bit is always the MSB of the shift register.
    w_led_nxt = (w_state_nxt == S_SHIFT) &&
                (w_cnt_nxt < (w_shift_nxt[23] ? C_T1H : C_T0H));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_led     <= w_led_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_ws2812_string_driver.sv
module tb_ws2812_string_driver;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TRST = 20;
  localparam int AW   = 2;
  localparam int PIX  = 24 * TBIT;
  localparam int HN   = 32768;
  localparam int BOUND = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          led, busy, done;
  logic [AW:0]   level;

  ws2812_string_driver_if pix ();

  ws2812_string_driver #(
    .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST), .FIFO_AW(AW)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .pix          (pix),
    .led_o        (led),
    .busy_o       (busy),
    .fifo_level_o (level),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic led_hist  [HN];
  logic done_hist [HN];
  int   max_level = 0;
  int   ready_bad = 0;
  bit   saw_full  = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [23:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle record of the outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < HN) begin
      led_hist[cyc]  = led;
      done_hist[cyc] = done;
    end
    if (int'(level) > max_level) max_level = int'(level);
    if (pix.pix_ready_o !== (level != 3'd4)) ready_bad++;
    if (level == 3'd4 && pix.pix_ready_o === 1'b0) saw_full = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the first rise of a gap-free frame.
  function automatic logic exp_led(input int k);
    int   p, b, ph;
    logic bv;
    logic [23:0] w;
    p  = k / PIX;
    b  = (k / TBIT) % 24;
    ph = k % TBIT;
    w  = exp_q[p];
    bv = w[23 - b];
    return (ph < (bv ? T1H : T0H));
  endfunction

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send(input logic [23:0] w);
    int n;
    pix.pix_valid_i = 1'b1;
    pix.pix_data_i  = w;
    n = 0;
    while (pix.pix_ready_o !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait", 32'(n < BOUND), 1);
    @(negedge clk);
  endtask

  // Waits for done_o, then checks the recorded frame against exp_q.
  task automatic check_frame(input string tag, input int s, output int r, output int d);
    int n, dcnt, mism, len;
    len = PIX * exp_q.size();
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(n < 6000), 1);
    @(negedge clk);
    @(negedge clk);
    r = -1; d = -1; dcnt = 0;
    for (int c = s; c < cyc && c < HN; c++) begin
      if (r < 0 && led_hist[c] === 1'b1) r = c;
      if (done_hist[c] === 1'b1) begin
        if (d < 0) d = c;
        dcnt++;
      end
    end
    chk({tag, "_rise_found"}, 32'(r >= 0), 1);
    if (r < 0) r = s;
    if (d < 0) d = r;
    chk({tag, "_done_latency"}, d - r, len + TRST + 1);
    mism = 0;
    for (int k = 0; k < len && (r + k) < HN; k++)
      if (led_hist[r + k] !== exp_led(k)) mism++;
    chk({tag, "_waveform"}, mism, 0);
    mism = 0;
    for (int c = r + len; c <= d && c < HN; c++)
      if (led_hist[c] !== 1'b0) mism++;
    chk({tag, "_latch_low"}, mism, 0);
    chk({tag, "_done_count"}, dcnt, 1);
  endtask

  initial begin
    int s, r, d, r2, d2, n, rc, rs, cnt_led, cnt_done;
    logic [23:0] w, wa, wb;

    pix.pix_valid_i = 1'b0;
    pix.pix_data_i  = '0;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(pix.pix_ready_o), 1);
    chk("rst_level", 32'(level), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single pixel with first-transaction timing.
    s = cyc;
    send(24'h800001);
    pix.pix_valid_i = 1'b0;
    chk("single_level_after_push", 32'(level), 1);
    chk("single_led_before_pop", 32'(led), 0);
    @(negedge clk);
    chk("single_led_rise", 32'(led), 1);
    chk("single_busy", 32'(busy), 1);
    chk("single_level_after_pop", 32'(level), 0);
    exp_q.delete();
    exp_q.push_back(24'h800001);
    check_frame("single", s, r, d);
    chk("single_idle_busy", 32'(busy), 0);

    // Two back-to-back pixels.
    s = cyc;
    exp_q.delete();
    exp_q.push_back(24'hFFFFFF);
    exp_q.push_back(24'h000000);
    send(24'hFFFFFF);
    send(24'h000000);
    pix.pix_valid_i = 1'b0;
    check_frame("pair", s, r, d);

    // Backpressure: seven random words with valid held high.
    s = cyc;
    exp_q.delete();
    max_level = 0;
    saw_full  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w = 24'($urandom());
      exp_q.push_back(w);
      send(w);
    end
    pix.pix_valid_i = 1'b0;
    check_frame("bp", s, r, d);
    chk("bp_max_level", max_level, 4);
    chk("bp_saw_full", 32'(saw_full), 1);
    chk("ready_vs_level", ready_bad, 0);

    // Reset 70 cycles into a pixel with a second word queued.
    wa = 24'($urandom());
    wb = 24'($urandom());
    send(wa);
    send(wb);
    pix.pix_valid_i = 1'b0;
    n = 0;
    while (led !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rm_rise_seen", 32'(n < 400), 1);
    rc = cyc;
    while (cyc < rc + 70) @(negedge clk);
    chk("rm_level_before", 32'(level), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_led", 32'(led), 0);
    chk("rm_level", 32'(level), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_done", 32'(done), 0);
    chk("rm_ready", 32'(pix.pix_ready_o), 1);
    rst = 1'b0;
    rs = cyc;
    repeat (60) @(negedge clk);
    cnt_led = 0; cnt_done = 0;
    for (int c = rs; c < cyc; c++) begin
      if (led_hist[c] !== 1'b0) cnt_led++;
      if (done_hist[c] !== 1'b0) cnt_done++;
    end
    chk("rm_quiet_led", cnt_led, 0);
    chk("rm_no_done", cnt_done, 0);
    s = cyc;
    w = 24'($urandom());
    exp_q.delete();
    exp_q.push_back(w);
    send(w);
    pix.pix_valid_i = 1'b0;
    check_frame("rm_after", s, r, d);

    // Push during the latch; latch must not be shortened.
    s  = cyc;
    wa = 24'($urandom());
    wb = 24'($urandom());
    send(wa);
    pix.pix_valid_i = 1'b0;
    n = 0;
    while (led !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("lp_rise_seen", 32'(n < 400), 1);
    rc = cyc;
    while (cyc < rc + PIX + 9) @(negedge clk);
    send(wb);
    pix.pix_valid_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(wa);
    check_frame("lp_first", s, r, d);
    chk("lp_first_rise", r, rc);
    exp_q.delete();
    exp_q.push_back(wb);
    check_frame("lp_second", d + 1, r2, d2);
    chk("lp_second_rise", r2, d + 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
